golden_nonce_uart_tx: RTL and testbench

- Return path of the miner: takes golden-nonce pulses from the mining core, buffers them in a small FIFO and serialises each one over a UART 8N1 line to the host.
- Sits between the fpgaminer_top result output and the board TX pin.
- It is the outbound counterpart to the work-load path that fills midstate_buf, data_buf and nonce.

---
 rtl/golden_nonce_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_golden_nonce_uart_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/golden_nonce_uart_tx.sv
// rtl/golden_nonce_uart_tx.sv - golden-nonce FIFO feeding a UART 8N1 transmitter, MSB byte first.
// Optional XOR checksum byte per frame when GOLDEN_NONCE_CHECKSUM_EN is defined.
module golden_nonce_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [31:0]                   golden_nonce,
  input  logic                          golden_nonce_valid,
  input  logic                          clear_overflow,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
`ifdef GOLDEN_NONCE_CHECKSUM_EN
  localparam int       SH_W      = 40;
  localparam bit [2:0] LAST_BYTE = 3'd4;
`else
  localparam int       SH_W      = 32;
  localparam bit [2:0] LAST_BYTE = 3'd3;
`endif
  localparam logic [PTR_W:0] FULL_CNT   = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [31:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [SH_W-1:0]    sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [2:0]         byte_idx_q, byte_idx_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               pop, accept, drop;
  logic [31:0]        rd_data;
  logic [7:0]         cur_byte;

  assign rd_data  = mem_q[rd_ptr_q];
  assign cur_byte = sh_q[SH_W-1 -: 8];

  always_comb begin
    pop      = (state_q == IDLE) && (count_q != '0);
    accept   = golden_nonce_valid && ((count_q != FULL_CNT) || pop);
    drop     = golden_nonce_valid && !accept;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) begin
      mem_d[wr_ptr_q] = golden_nonce;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d    = count_q + (PTR_W + 1)'(accept) - (PTR_W + 1)'(pop);
    // A drop and a clear in the same cycle must leave the flag set.
    overflow_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
`ifdef GOLDEN_NONCE_CHECKSUM_EN
          sh_d = {rd_data, rd_data[31:24] ^ rd_data[23:16] ^ rd_data[15:8] ^ rd_data[7:0]};
`else
          sh_d = rd_data;
`endif
          byte_idx_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = CNT_LOAD;
        state_d = START;
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d     = CNT_LOAD;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_LOAD;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (byte_idx_q < LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 1'b1;
            sh_d       = sh_q << 8;
            cnt_d      = CNT_LOAD;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and busy are registered from the current state, so they trail it by one clock.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    if (state_q == START) txd_d = 1'b0;
    else if (state_q == DATA) txd_d = cur_byte[bit_idx_q];
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sh_q       <= '0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  assign uart_txd   = txd_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// tb/tb_golden_nonce_uart_tx.sv - directed self-checking bench for golden_nonce_uart_tx.
module tb_golden_nonce_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef GOLDEN_NONCE_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n, golden_nonce_valid, clear_overflow;
  logic [31:0] golden_nonce;
  logic        uart_txd, busy, overflow;
  logic [$clog2(DEPTH):0] fifo_count;
  int cyc = 0, checks = 0, errors = 0;

  always #5 clk = ~clk;

  golden_nonce_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .golden_nonce(golden_nonce),
    .golden_nonce_valid(golden_nonce_valid), .clear_overflow(clear_overflow),
    .uart_txd(uart_txd), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse(input logic [31:0] v);
    golden_nonce       = v;
    golden_nonce_valid = 1'b1;
    tick();
    golden_nonce_valid = 1'b0;
  endtask

  function automatic logic [39:0] exp_frame(input logic [31:0] n);
`ifdef GOLDEN_NONCE_CHECKSUM_EN
    return {n, n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0]};
`else
    return {8'h00, n};
`endif
  endfunction

  task automatic wait_start(output int s);
    int t = 0;
    while (uart_txd !== 1'b0 && t < 3000) begin
      tick();
      t++;
    end
    check("start_timeout", {39'd0, uart_txd}, 40'd0);
    s = cyc;
  endtask

  task automatic rx_frame_at(input int s, output logic [39:0] d);
    logic [7:0] by;
    logic       ok;
    int         base;
    ok = 1'b1;
    d  = '0;
    for (int b = 0; b < NB; b++) begin
      base = s + 10 * CPB * b;
      step_to(base + CPB / 2);
      if (uart_txd !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        step_to(base + CPB * (i + 1) + CPB / 2);
        by[i] = uart_txd;
      end
      step_to(base + 9 * CPB + CPB / 2);
      if (uart_txd !== 1'b1) ok = 1'b0;
      d = {d[31:0], by};
    end
    check("framing", {39'd0, ok}, 40'd1);
  endtask

  task automatic rx_frame(output logic [39:0] d, output int s);
    wait_start(s);
    rx_frame_at(s, d);
  endtask

  logic [39:0] d;
  int          c0, s, s1, s2;
  int          exp_cnt [6] = '{1, 1, 2, 3, 4, 4};

  initial begin
    reset_n = 1'b0; golden_nonce_valid = 1'b0; clear_overflow = 1'b0; golden_nonce = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_txd", {39'd0, uart_txd}, 40'd1);
      check("rst_busy", {39'd0, busy}, 40'd0);
      check("rst_count", {37'd0, fifo_count}, 40'd0);
      check("rst_ovf", {39'd0, overflow}, 40'd0);
    end
    reset_n = 1'b1;
    tick();

    pulse(32'h0e33337a);
    c0 = cyc;
    check("single_count1", {37'd0, fifo_count}, 40'd1);
    tick();
    check("single_count0", {37'd0, fifo_count}, 40'd0);
    rx_frame(d, s);
    check("single_latency", 40'(s - c0), 40'd3);
    check("single_data", d, exp_frame(32'h0e33337a));
    step_to(s + NB * 10 * CPB - 1);
    check("single_busy_last", {39'd0, busy}, 40'd1);
    tick();
    check("single_busy_end", {39'd0, busy}, 40'd0);
    check("single_idle_txd", {39'd0, uart_txd}, 40'd1);

    pulse(32'hdeadbeef);
    c0 = cyc;
    pulse(32'h00000001);
    rx_frame(d, s1);
    check("b2b_latency", 40'(s1 - c0), 40'd3);
    check("b2b_data0", d, exp_frame(32'hdeadbeef));
    rx_frame(d, s2);
    check("b2b_gap", 40'(s2 - s1), 40'(NB * 10 * CPB + 2));
    check("b2b_data1", d, exp_frame(32'h00000001));

    step_to(cyc + 10);
    for (int v = 1; v <= 6; v++) begin
      pulse(32'(v));
      if (v == 1) c0 = cyc;
      check("ovf_count", {37'd0, fifo_count}, 40'(exp_cnt[v-1]));
    end
    check("ovf_set", {39'd0, overflow}, 40'd1);
    rx_frame_at(c0 + 3, d);
    check("ovf_frame1", d, exp_frame(32'd1));
    for (int v = 2; v <= 5; v++) begin
      rx_frame(d, s);
      check("ovf_frame", d, exp_frame(32'(v)));
    end
    step_to(cyc + 10);
    check("ovf_sticky", {39'd0, overflow}, 40'd1);
    check("ovf_drained", {37'd0, fifo_count}, 40'd0);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_cleared", {39'd0, overflow}, 40'd0);

    pulse(32'h11223344);
    pulse(32'h55667788);
    wait_start(s);
    step_to(s + 2 * 10 * CPB + 5);
    check("mid_count_pre", {37'd0, fifo_count}, 40'd1);
    reset_n = 1'b0;
    tick();
    check("mid_txd", {39'd0, uart_txd}, 40'd1);
    check("mid_count", {37'd0, fifo_count}, 40'd0);
    check("mid_busy", {39'd0, busy}, 40'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("mid_idle_txd", {39'd0, uart_txd}, 40'd1);
    pulse(32'ha5a50f0f);
    c0 = cyc;
    rx_frame(d, s);
    check("mid_latency", 40'(s - c0), 40'd3);
    check("mid_data", d, exp_frame(32'ha5a50f0f));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
